stream_cipher_lfsr: RTL
=======================

# stream_cipher_lfsr

Parametrised LFSR-keyed stream cipher with valid/ready streaming on both sides. Each accepted plaintext word is XORed with a keystream word from an internal Galois LFSR, which then advances DATA_W steps. The result is registered with one cycle of latency. Encryption and decryption are the same operation, so one block seeded identically at both ends serves both directions. The block sits between a message source and a transport/sink.

## Interface
- DATA_W, default 8: width of the data and keystream words; must satisfy 1 ≤ DATA_W ≤ LFSR_W.
- LFSR_W, default 16: width of the LFSR state.
- TAPS, default 16'hB400: Galois feedback mask (maximal length for 16 bits).
- SEED, default 16'hACE1: reset seed, also substituted for a zero seed_in.
- clk  in  1  clock; everything updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- seed_load  in  1  one-cycle strobe that loads the seed.
- seed_in  in  LFSR_W  seed value, sampled when seed_load=1.
- in_valid  in  1  plaintext word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  plaintext (or ciphertext when decrypting).
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts the output word.
- out_data  out  DATA_W  in_data XOR key.
- out_key  out  DATA_W  keystream word used for the current out_data.
- word_count  out  16  number of accepted words since reset or the last seed load; wraps at 16'hFFFF→0.

## Operation
- **Keystream.** key = lfsr[DATA_W-1:0].
  - One Galois step: if lsb=1, s = (s>>1)^TAPS; otherwise s = s>>1.
  - On accept, lfsr takes the result of DATA_W steps, computed combinationally in one cycle.
- **Accept.** A word is accepted when in_valid && in_ready.
  - in_ready = !seed_load && (!out_valid || out_ready).
- **On accept:**
  - out_data ← in_data^key
  - out_key ← key
  - out_valid ← 1
  - lfsr advances
  - word_count increments
- **Output.** out_valid clears on out_valid && out_ready when no word is accepted in the same cycle.
  - With simultaneous output handshake and accept, the register reloads and out_valid stays 1.
  - While out_valid=1 && out_ready=0, out_data and out_key hold.
- **Seed load.** It has priority over accept.
  - lfsr ← (seed_in==0) ? SEED : seed_in. This guards against the all-zero lockup state.
  - word_count ← 0.
  - A pending output word is kept and not flushed.
- **Invariants.**
  - lfsr never holds 0.
  - Keystream consumption is exactly one word per accept, regardless of output stalls.

## Timing
- **Reset values:**
  - lfsr = SEED
  - out_valid = 0
  - out_data = 0
  - out_key = 0
  - word_count = 0
  - in_ready = 1 (combinational: out_valid=0 and seed_load=0)
- **Reset mid-operation.** All state clears immediately and asynchronously. A pending output word is lost.
- **Latency.** 1 cycle from accept to out_valid.
- **Throughput.** 1 word per cycle while out_ready=1.
- **Seed load timing.** in_ready is low in the seed_load cycle. The new key applies to the first word accepted after it.
- **Combinational paths.** in_ready depends combinationally on out_ready and seed_load; there is no other combinational in→out path.

## Configuration
- **STREAM_CIPHER_LOOPBACK_EN defined.** Adds a self-check decryptor and two output ports, loop_data [DATA_W] and loop_err [1].
  - The block keeps a second LFSR, seeded and reset exactly like the first. It advances DATA_W steps on each output handshake (out_valid && out_ready).
  - The block registers the plaintext alongside out_data.
  - On each output handshake: loop_data ← out_data^loopkey.
  - loop_err is sticky and is set if loop_data ≠ stored plaintext.
  - loop_err clears only on reset or seed_load.
  - Both new ports reset to 0.
- **Macro undefined.** No loopback logic and no loop_* ports; the behaviour above is unchanged.

## Test plan
All scenarios use default parameters.
- **Reset and first word.** Release reset, then in_data=8'hAA with out_ready=1 → next cycle out_key=8'hE1, out_data=8'h4B, word_count=1.
- **Second word.** Next word in_data=8'hF0 → out_key=8'hC4, out_data=8'h34, word_count=2.
- **Backpressure.**
  - Hold out_ready=0 after one accepted word → in_ready=0, out_data holds for 5 cycles, lfsr does not advance.
  - Release out_ready → the next key is 8'hC4.
- **Seed handling.**
  - seed_load with seed_in=0 → behaves as SEED, and the next word 8'hAA gives 8'h4B.
  - seed_load asserted together with in_valid → no accept that cycle, word_count=0.
- **Mid-stream reset and round trip.**
  - Assert reset with out_valid=1 → out_valid=0 immediately and the keystream restarts at 8'hE1.
  - Feed 8'h4B after reset → out_data=8'hAA (decrypt round trip).
- **Loopback (STREAM_CIPHER_LOOPBACK_EN).** Stream 256 random words with random out_ready → loop_data matches every plaintext, loop_err=0, and word_count=256 wraps correctly over a later run of 65536 words.

Source files
------------

// File: rtl/stream_cipher_lfsr.sv
// stream_cipher_lfsr: Galois-LFSR keyed stream cipher with valid/ready handshakes on input and output
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   seed_load/seed_in  one-cycle strobe that reseeds the keystream (a zero seed maps to SEED)
//   in_valid/in_ready/in_data     plaintext (or ciphertext) input stream
//   out_valid/out_ready/out_data  output stream, out_data = in_data ^ key, one cycle of latency
//   out_key            keystream word that produced the current out_data
//   word_count         words accepted since reset or the last seed load, wraps at 16 bits
// Optional: define STREAM_CIPHER_LOOPBACK_EN to add a self-check decryptor with
//   loop_data (decrypted output word) and loop_err (sticky mismatch flag).
module stream_cipher_lfsr #(
  parameter int DATA_W = 8,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_key,
  output logic [15:0]       word_count
`ifdef STREAM_CIPHER_LOOPBACK_EN
  ,
  output logic [DATA_W-1:0] loop_data,
  output logic              loop_err
`endif
);
  // DATA_W Galois steps unrolled into one combinational cycle
  function automatic logic [LFSR_W-1:0] advance(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = s;
    for (int i = 0; i < DATA_W; i++) r = r[0] ? ((r >> 1) ^ TAPS) : (r >> 1);
    return r;
  endfunction
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, seed_val;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, out_key_q, out_key_d, key;
  logic [15:0]       word_count_q, word_count_d;
  logic              accept, out_hs;
  always_comb begin
    seed_val     = (seed_in == '0) ? SEED : seed_in;
    key          = lfsr_q[DATA_W-1:0];
    in_ready     = !seed_load && (!out_valid_q || out_ready);
    accept       = in_valid && in_ready;
    out_hs       = out_valid_q && out_ready;
    lfsr_d       = seed_load ? seed_val : accept ? advance(lfsr_q) : lfsr_q;
    word_count_d = seed_load ? 16'd0 : accept ? word_count_q + 16'd1 : word_count_q;
    out_valid_d  = accept ? 1'b1 : out_hs ? 1'b0 : out_valid_q;
    out_data_d   = accept ? (in_data ^ key) : out_data_q;
    out_key_d    = accept ? key : out_key_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q       <= SEED;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_key_q    <= '0;
      word_count_q <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_key_q    <= out_key_d;
      word_count_q <= word_count_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_key    = out_key_q;
  assign word_count = word_count_q;
`ifdef STREAM_CIPHER_LOOPBACK_EN
  // Receiver-side twin: its keystream advances per delivered word, so it decrypts what the sink sees
  logic [LFSR_W-1:0] loop_lfsr_q, loop_lfsr_d;
  logic [DATA_W-1:0] plain_q, plain_d, loop_data_q, loop_data_d, loop_dec;
  logic              loop_err_q, loop_err_d;
  always_comb begin
    loop_dec    = out_data_q ^ loop_lfsr_q[DATA_W-1:0];
    loop_lfsr_d = seed_load ? seed_val : out_hs ? advance(loop_lfsr_q) : loop_lfsr_q;
    plain_d     = accept ? in_data : plain_q;
    loop_data_d = out_hs ? loop_dec : loop_data_q;
    loop_err_d  = seed_load ? 1'b0 : (out_hs && loop_dec != plain_q) ? 1'b1 : loop_err_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loop_lfsr_q <= SEED;
      plain_q     <= '0;
      loop_data_q <= '0;
      loop_err_q  <= 1'b0;
    end else begin
      loop_lfsr_q <= loop_lfsr_d;
      plain_q     <= plain_d;
      loop_data_q <= loop_data_d;
      loop_err_q  <= loop_err_d;
    end
  end
  assign loop_data = loop_data_q;
  assign loop_err  = loop_err_q;
`endif
endmodule
